sync_ram_dp: RTL and testbench
==============================

Name: sync_ram_dp

Overview:
Parametrised simple dual-port synchronous RAM. It is the successor to the single-port sync_ram.
- Independent write and read ports in the same clock domain.
- Per-byte write enables and a selectable read latency of 1 or 2.
- Configurable read-during-write collision behaviour.
- Optional post-reset zero-fill sweep driven by an internal FSM.

It serves as the general scratch/buffer memory for datapath blocks and is the building block for future FIFOs.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2; anything else is an elaboration error.
- RDW_MODE, 0, same-address read/write collision: 0 = old data, 1 = new data (write-through, byte-merged).
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset release; 0 = no sweep, contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- we  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers write_data[8i+7:8i].
- re  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- read_data  out  DATA_WIDTH  read data; holds its value between reads.
- rd_valid  out  1  single-cycle pulse marking read_data as new.
- init_busy  out  1  high while the zero-fill sweep runs; requests are ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - read_data = 0, rd_valid = 0.
  - Read pipeline flushed.
  - FSM enters INIT if CLEAR_ON_RESET = 1 (init_busy = 1), otherwise RUN (init_busy = 0).
  - The array itself is not reset.
- FSM states: INIT and RUN.
- INIT:
  - One word per cycle is written to 0, starting at address 0 on the first edge after rst_n rises.
  - The sweep counter increments through DEPTH-1.
  - On the edge that writes DEPTH-1, the FSM moves to RUN; init_busy falls with that edge.
  - The sweep takes exactly DEPTH cycles.
- Requests during INIT: we and re are ignored. Nothing is written, no rd_valid is produced, and nothing is queued.
- Reset asserted mid-INIT: the sweep aborts and restarts from address 0 after release.
- Write (RUN):
  - we = 1 at edge N updates only the bytes whose wr_be bit is set, at wr_addr.
  - wr_be = 0 is a legal no-op.
- Read (RUN):
  - re = 1 sampled at edge N gives read_data and rd_valid = 1 after edge N + RD_LATENCY.
  - rd_valid lasts one cycle per accepted read.
  - Back-to-back reads give full throughput: one result per cycle.
  - With re = 0, rd_valid = 0 and read_data keeps its last value.
- Collision (we and re in the same cycle, wr_addr == rd_addr):
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns the pre-write word with the enabled bytes replaced by write_data.
  - The write is always performed.
- Different addresses in the same cycle: the operations are independent, with no stall.
- Addresses cover the full 2**ADDR_WIDTH range; there is no out-of-range case.
- The RD_LATENCY = 2 pipeline stage is purely registered.
  - A later write to the same address does not affect a read already in flight.
  - Reset clears its valid bit.

Decomposition:
- Package sync_ram_pkg holds:
  - state enum ram_state_e {INIT, RUN};
  - localparam RD_LAT_MIN = 1 and RD_LAT_MAX = 2;
  - function be_merge(old, new, be), used by the write path and by RDW_MODE 1.
- One natural sub-module, sync_ram_rd_pipe: a parametrised delay line of data plus valid, depth RD_LATENCY-1, with async active-low reset.
- The array and the FSM stay in the top module.

Test Plan:
1. Reset and zero-fill (DEPTH 16, CLEAR_ON_RESET 1):
   - Stimulus: release rst_n, hold re = 1 on address 3 throughout.
   - Required: init_busy is high for exactly 16 cycles; no rd_valid during the sweep; the first read afterwards returns 0x00000000.
2. Byte-enable write:
   - Stimulus: write 0xAABBCCDD to address 5 with wr_be 4'hF, then 0x11223344 with wr_be 4'b0101.
   - Required: reading address 5 returns 0xAA22CC44.
3. Latency and throughput:
   - Stimulus: reads of addresses 1, 2, 3 on consecutive cycles.
   - RD_LATENCY 1: rd_valid high on 3 consecutive cycles, starting 1 cycle after the first re.
   - RD_LATENCY 2: same, starting 2 cycles after the first re.
   - Required: data in order 1, 2, 3.
4. Collision:
   - Setup: address 7 holds 0x01020304.
   - Stimulus: same cycle, write 0xFFFFFFFF with wr_be 4'b0011 and read address 7.
   - RDW_MODE 0 returns 0x01020304; RDW_MODE 1 returns 0x0102FFFF.
   - Required: a later read returns 0x0102FFFF in both modes.
5. Reset mid-operation:
   - Stimulus: assert rst_n low during an RD_LATENCY 2 read in flight and mid-sweep.
   - Required: read_data = 0 and rd_valid = 0 immediately; the in-flight read is never reported; the sweep restarts at address 0 and runs a full 16 cycles.
6. Address wrap:
   - Stimulus: write address 15 = 0xDEADBEEF and address 0 = 0x12345678 (ADDR_WIDTH 4).
   - Required: both read back exactly, with no aliasing.

Source files
------------

// File: rtl/sync_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_pkg
//  Purpose  : Shared types, constants and the byte-merge helper used by the
//             sync_ram_dp family.
//  Contents : ram_state_e          - INIT (zero-fill sweep) / RUN
//             RD_LAT_MIN/RD_LAT_MAX - legal read latency range
//             be_merge()            - byte-enable merge of two words
//  Revision : 1.0 - initial release
// ============================================================================
package sync_ram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // be_merge works on a fixed maximum width so that it can live in the
    // package; callers zero-extend their words in and truncate the result out.
    localparam int BE_MAX_DATA_WIDTH = 1024;
    localparam int BE_MAX_BYTES      = BE_MAX_DATA_WIDTH / 8;

    // Returns old_word with every byte whose enable bit is set replaced by the
    // corresponding byte of new_word.
    function automatic logic [BE_MAX_DATA_WIDTH-1:0] be_merge(
        input logic [BE_MAX_DATA_WIDTH-1:0] old_word,
        input logic [BE_MAX_DATA_WIDTH-1:0] new_word,
        input logic [BE_MAX_BYTES-1:0]      be
    );
        logic [BE_MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_MAX_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_rd_pipe
//  Purpose  : Registered delay line for read data plus its valid flag.
//             Data registers only load when the incoming valid is set, so the
//             output word holds its value between reads.
//  Ports    : clk       in   clock
//             rst_n     in   asynchronous reset, active-low
//             data_i    in   read data entering the line
//             valid_i   in   valid flag entering the line
//             data_o    out  delayed read data
//             valid_o   out  delayed valid flag
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("sync_ram_rd_pipe: STAGES must be at least 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0]     valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign data_o  = data_q[STAGES-1];
    assign valid_o = valid_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ram_dp
//  Purpose  : Simple dual-port synchronous RAM (one write port, one read
//             port, single clock) with per-byte write enables, read latency
//             of 1 or 2, selectable read-during-write behaviour and an
//             optional zero-fill sweep after reset.
//  Ports    : clk         in   clock, all state changes on the rising edge
//             rst_n       in   asynchronous reset, active-low
//             we          in   write request
//             wr_addr     in   write address
//             write_data  in   write data
//             wr_be       in   byte enables (bit i -> write_data[8i+7:8i])
//             re          in   read request
//             rd_addr     in   read address
//             read_data   out  read data, holds between reads
//             rd_valid    out  one-cycle pulse per completed read
//             init_busy   out  high while the zero-fill sweep runs
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam ram_state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
            $error("sync_ram_dp: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
            $error("sync_ram_dp: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (DATA_WIDTH > BE_MAX_DATA_WIDTH) begin : g_too_wide
            $error("sync_ram_dp: DATA_WIDTH exceeds the be_merge maximum width");
        end
        if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw_mode
            $error("sync_ram_dp: RDW_MODE must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage (never reset; the sweep provides the defined contents)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Zero-fill FSM
    // ------------------------------------------------------------------
    ram_state_e            state_q;
    ram_state_e            state_d;
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic [ADDR_WIDTH-1:0] sweep_d;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + ADDR_WIDTH'(1);
            if (sweep_q == LAST_ADDR) begin
                state_d = RUN;
                sweep_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign init_busy = (state_q == INIT);

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    logic                  run_w;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign run_w = (state_q == RUN);

    // Stored word at the write address with the enabled bytes replaced. Also
    // the write-through value for a same-address read in RDW_MODE 1.
    assign wr_merged = DATA_WIDTH'(be_merge(BE_MAX_DATA_WIDTH'(mem_q[wr_addr]),
                                            BE_MAX_DATA_WIDTH'(write_data),
                                            BE_MAX_BYTES'(wr_be)));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_merged;
        if (state_q == INIT) begin
            // Sweep owns the write port; user writes are dropped.
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
        end else if (we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port, first register stage
    // ------------------------------------------------------------------
    logic                  rd_accept;
    logic                  rd_collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    assign rd_accept  = run_w && re;
    assign rd_collide = rd_accept && we && (wr_addr == rd_addr);

    always_comb begin
        rd_word = mem_q[rd_addr];
        if (RDW_MODE == 1 && rd_collide) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            // Only load on a read so the word holds between reads.
            if (rd_accept) begin
                rd_data_q <= rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional extra latency
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY > RD_LAT_MIN) begin : g_rd_pipe
            sync_ram_rd_pipe #(
                .DATA_WIDTH (DATA_WIDTH),
                .STAGES     (RD_LATENCY - 1)
            ) u_rd_pipe (
                .clk     (clk),
                .rst_n   (rst_n),
                .data_i  (rd_data_q),
                .valid_i (rd_valid_q),
                .data_o  (read_data),
                .valid_o (rd_valid)
            );
        end else begin : g_rd_direct
            assign read_data = rd_data_q;
            assign rd_valid  = rd_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_ram_dp
//  Purpose  : Self-checking bench for sync_ram_dp. Two instances share the
//             stimulus: A (latency 1, old-data collisions) and B (latency 2,
//             write-through collisions). Expected read results are pushed to
//             per-instance queues with the cycle they are due; a monitor pops
//             and compares whenever an instance raises rd_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ram_dp;

    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  wr_addr;
    logic [31:0] write_data;
    logic [3:0]  wr_be;
    logic        re;
    logic [3:0]  rd_addr;
    logic [31:0] dat_a, dat_b;
    logic        vld_a, vld_b;
    logic        busy_a, busy_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
        int          tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tag_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_ram_dp #(
        .DATA_WIDTH (32), .ADDR_WIDTH (4), .RD_LATENCY (LAT_A),
        .RDW_MODE (0), .CLEAR_ON_RESET (1)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .we (we), .wr_addr (wr_addr),
        .write_data (write_data), .wr_be (wr_be), .re (re), .rd_addr (rd_addr),
        .read_data (dat_a), .rd_valid (vld_a), .init_busy (busy_a)
    );

    sync_ram_dp #(
        .DATA_WIDTH (32), .ADDR_WIDTH (4), .RD_LATENCY (LAT_B),
        .RDW_MODE (1), .CLEAR_ON_RESET (1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .we (we), .wr_addr (wr_addr),
        .write_data (write_data), .wr_be (wr_be), .re (re), .rd_addr (rd_addr),
        .read_data (dat_b), .rd_valid (vld_b), .init_busy (busy_b)
    );

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic mon_port(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        int   n;
        n = (p == 0) ? q_a.size() : q_b.size();
        if (n > 0) begin
            if (p == 0) e = q_a[0];
            else        e = q_b[0];
        end
        if (v) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid dut%0d cycle %0d: got data %h, required no rd_valid", p, cyc, d);
            end else begin
                if (p == 0) void'(q_a.pop_front());
                else        void'(q_b.pop_front());
                if (d !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read%0d dut%0d: got %h at cycle %0d, required %h at cycle %0d",
                             e.tag, p, d, cyc, e.data, e.due);
                end
            end
        end else if (n > 0 && cyc >= e.due) begin
            checks++;
            errors++;
            if (p == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
            $display("FAIL read%0d dut%0d: got no rd_valid by cycle %0d, required %h at cycle %0d",
                     e.tag, p, cyc, e.data, e.due);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, vld_a, dat_a);
        mon_port(1, vld_b, dat_b);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One cycle of traffic. ea/eb are the hand-computed read results for
    // instance A (old-data) and B (write-through).
    task automatic op(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic r, input logic [3:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        we = w; wr_addr = wa; write_data = wd; wr_be = be;
        re = r; rd_addr = ra;
        if (r) begin
            tag_n++;
            e.tag = tag_n;
            e.data = ea; e.due = cyc + LAT_A; q_a.push_back(e);
            e.data = eb; e.due = cyc + LAT_B; q_b.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0);
    endtask

    // Counts cycles with init_busy high, starting at the current cycle.
    task automatic wait_sweep(input logic drop_we);
        int cnt_a = 0;
        int cnt_b = 0;
        int guard = 0;
        while ((busy_a || busy_b) && guard < 40) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            guard++;
            // Release the write request before the first RUN edge.
            if (drop_we && guard >= 16) we = 1'b0;
            @(posedge clk); #1;
        end
        chk("init_busy_cycles_a", 32'(cnt_a), 32'd16);
        chk("init_busy_cycles_b", 32'(cnt_b), 32'd16);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_data_a"}, dat_a, 32'h0);
        chk({tag, "_read_data_b"}, dat_b, 32'h0);
        chk({tag, "_rd_valid_a"}, 32'(vld_a), 32'h0);
        chk({tag, "_rd_valid_b"}, 32'(vld_b), 32'h0);
        chk({tag, "_init_busy_a"}, 32'(busy_a), 32'h1);
        chk({tag, "_init_busy_b"}, 32'(busy_b), 32'h1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; we = 1'b0; wr_addr = '0; write_data = '0; wr_be = '0;
        re = 1'b0; rd_addr = '0;
        @(posedge clk); #1;
        chk_reset_outputs("reset");

        // Zero-fill with a read of address 3 held throughout.
        re = 1'b1; rd_addr = 4'd3;
        rst_n = 1'b1;
        wait_sweep(1'b0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h0000_0000, 32'h0000_0000);

        // Byte-enable write.
        op(1'b1, 4'd5, 32'hAABB_CCDD, 4'hF,    1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        // Back-to-back reads.
        op(1'b1, 4'd1, 32'h1111_1111, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'd2, 32'h2222_2222, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'd3, 32'h3333_3333, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1, 32'h1111_1111, 32'h1111_1111);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2, 32'h2222_2222, 32'h2222_2222);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'h3333_3333, 32'h3333_3333);
        idle(3);
        chk("hold_read_data_a", dat_a, 32'h3333_3333);
        chk("hold_read_data_b", dat_b, 32'h3333_3333);

        // Same-address collision.
        op(1'b1, 4'd7, 32'h0102_0304, 4'hF,    1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b0011, 1'b1, 4'd7, 32'h0102_0304, 32'h0102_FFFF);
        op(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd7, 32'h0102_FFFF, 32'h0102_FFFF);

        // Different addresses in one cycle, then a zero-enable write.
        op(1'b1, 4'd8, 32'h5555_5555, 4'hF, 1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        op(1'b1, 4'd5, 32'h0000_0000, 4'h0, 1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        op(1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd8, 32'h5555_5555, 32'h5555_5555);
        op(1'b0, 4'd0, 32'h0,         4'h0, 1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        // Address range ends.
        op(1'b1, 4'd15, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'd0,  32'h1234_5678, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b0, 4'd0,  32'h0, 4'h0, 1'b1, 4'd15, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        op(1'b0, 4'd0,  32'h0, 4'h0, 1'b1, 4'd0,  32'h1234_5678, 32'h1234_5678);
        idle(4);

        // Reset with a read in flight in instance B.
        re = 1'b1; rd_addr = 4'd5;
        @(posedge clk); #1;
        rst_n = 1'b0; re = 1'b0;
        #1;
        chk_reset_outputs("reset_inflight");
        q_a.delete();
        q_b.delete();
        @(posedge clk); @(posedge clk); #1;

        // Reset again partway through the sweep.
        rst_n = 1'b1;
        idle(5);
        chk("mid_sweep_busy_a", 32'(busy_a), 32'h1);
        chk("mid_sweep_busy_b", 32'(busy_b), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_sweep");
        @(posedge clk); #1;

        // Full restarted sweep with write and read requests held (ignored).
        we = 1'b1; wr_addr = 4'd0; write_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        re = 1'b1; rd_addr = 4'd3;
        rst_n = 1'b1;
        wait_sweep(1'b1);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0,  32'h0, 32'h0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 32'h0, 32'h0);
        op(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5,  32'h0, 32'h0);
        idle(5);

        chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion by 100000, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
